// File: rtl/swervolf_axi_pkg.sv
// Shared encodings for the SweRVolf AXI-to-SRAM bridge: burst types,
// response codes and the bridge FSM state enum.
package swervolf_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_WRESP = 2'd2,
        ST_RD    = 2'd3
    } axi2sram_state_e;

endpackage

// File: rtl/swervolf_axi2sram_rdbuf.sv
// Two-entry read-data FIFO of {data, last}; the occupancy count feeds the
// read-issue credit so the R channel can stall without losing SRAM data.
module swervolf_axi2sram_rdbuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [63:0] data_i,
    input  logic        last_i,
    input  logic        pop_i,
    output logic [63:0] data_o,
    output logic        last_o,
    output logic [1:0]  count_o
);

    logic [63:0] data_q [2];
    logic [1:0]  last_q;
    logic        wptr_q;
    logic        rptr_q;
    logic [1:0]  count_q;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= 64'd0;
            data_q[1] <= 64'd0;
            last_q    <= 2'b00;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wptr_q] <= data_i;
                last_q[wptr_q] <= last_i;
                wptr_q         <= ~wptr_q;
            end
            if (pop_i) begin
                rptr_q <= ~rptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = data_q[rptr_q];
    assign last_o  = last_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/swervolf_axi2sram.sv
// AXI4 slave to single-port synchronous SRAM bridge: one transaction at a
// time, round-robin between AW and AR, one SRAM access per beat.
module swervolf_axi2sram
    import swervolf_axi_pkg::*;
#(
    parameter int  ID_WIDTH = 6,
    parameter int  MEM_SIZE = 32'h10000,
    localparam int AW       = $clog2(MEM_SIZE) - 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic                o_sram_en,
    output logic                o_sram_we,
    output logic [AW-1:0]       o_sram_addr,
    output logic [7:0]          o_sram_be,
    output logic [63:0]         o_sram_wdata,
    input  logic [63:0]         i_sram_rdata
);

    localparam int LAW = AW + 3;

    axi2sram_state_e     state_q, state_d;
    logic                prio_q, prio_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [LAW-1:0]      addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic                rd_done_q, rd_done_d;
    logic                infl_q, infl_d;
    logic                infl_last_q, infl_last_d;

    logic [LAW-1:0]      step_s;
    logic [1:0]          buf_count_s;
    logic [63:0]         buf_data_s;
    logic                buf_last_s;
    logic                buf_valid_s;
    logic                pop_s;
    logic [2:0]          occ_s;
    logic                unused_s;

    swervolf_axi2sram_rdbuf u_rdbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (infl_q),
        .data_i  (i_sram_rdata),
        .last_i  (infl_last_q),
        .pop_i   (pop_s),
        .data_o  (buf_data_s),
        .last_o  (buf_last_s),
        .count_o (buf_count_s)
    );

    assign step_s      = (burst_q == BURST_FIXED) ? {LAW{1'b0}} : (LAW'(1'b1) << size_q);
    assign buf_valid_s = (buf_count_s != 2'd0);
    assign pop_s       = buf_valid_s && i_rready;
    // Occupancy after this cycle's pop, so a streaming read keeps one issue per cycle.
    assign occ_s       = {1'b0, buf_count_s} + {2'b00, infl_q} - {2'b00, pop_s};

    assign o_sram_addr = addr_q[LAW-1:3];
    assign o_bid       = id_q;
    assign o_bresp     = RESP_OKAY;
    assign o_rid       = id_q;
    assign o_rresp     = RESP_OKAY;
    assign o_rdata     = buf_data_s;
    assign o_rvalid    = buf_valid_s;
    assign o_rlast     = buf_last_s && buf_valid_s;
    assign unused_s    = ^{i_awaddr[31:LAW], i_araddr[31:LAW], i_wlast};

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
            rd_done_q   <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            rd_done_q   <= rd_done_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Next-state, handshakes and SRAM access generation
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        burst_d      = burst_q;
        rd_done_d    = rd_done_q;
        infl_d       = 1'b0;
        infl_last_d  = 1'b0;
        o_awready    = 1'b0;
        o_arready    = 1'b0;
        o_wready     = 1'b0;
        o_bvalid     = 1'b0;
        o_sram_en    = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_be    = 8'h00;
        o_sram_wdata = 64'd0;
        case (state_q)
            ST_IDLE: begin
                // Readies are combinational here, so hold them low while in reset.
                if (rst_n && i_awvalid && (!i_arvalid || !prio_q)) begin
                    o_awready = 1'b1;
                    id_d      = i_awid;
                    addr_d    = i_awaddr[LAW-1:0];
                    len_d     = i_awlen;
                    size_d    = i_awsize;
                    burst_d   = i_awburst;
                    cnt_d     = 8'd0;
                    state_d   = ST_WR;
                end else if (rst_n && i_arvalid) begin
                    o_arready = 1'b1;
                    id_d      = i_arid;
                    addr_d    = i_araddr[LAW-1:0];
                    len_d     = i_arlen;
                    size_d    = i_arsize;
                    burst_d   = i_arburst;
                    cnt_d     = 8'd0;
                    rd_done_d = 1'b0;
                    state_d   = ST_RD;
                end else begin
                    state_d   = ST_IDLE;
                end
                if (i_awvalid && i_arvalid) begin
                    prio_d = ~prio_q;
                end else begin
                    prio_d = prio_q;
                end
            end
            ST_WR: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    o_sram_en    = 1'b1;
                    o_sram_we    = 1'b1;
                    o_sram_be    = i_wstrb;
                    o_sram_wdata = i_wdata;
                    addr_d       = addr_q + step_s;
                    if (cnt_q == len_q) begin
                        state_d = ST_WRESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WRESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            ST_RD: begin
                if (!rd_done_q && (occ_s < 3'd2)) begin
                    o_sram_en   = 1'b1;
                    o_sram_be   = 8'hFF;
                    infl_d      = 1'b1;
                    infl_last_d = (cnt_q == len_q);
                    addr_d      = addr_q + step_s;
                    if (cnt_q == len_q) begin
                        rd_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    infl_d = 1'b0;
                end
                if (pop_s && buf_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
